// File: rtl/cmd_resp_sequencer.sv
// Command/response sequencer: hands wrapper commands to the execution unit,
// watches for completion with a watchdog, and arbitrates the UART response channel.
module cmd_resp_sequencer #(
   parameter logic [7:0]  ACK_BYTE    = 8'hA5,
   parameter logic [7:0]  NAK_BYTE    = 8'hEE,
   parameter int unsigned TIMEOUT_CYC = 1000000,
   parameter int unsigned TMR_W       = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_rdy,
   input  logic [15:0] cmd,
   output logic        clr_cmd_rdy,
   output logic        send_resp,
   output logic [7:0]  resp,
   input  logic        resp_sent,
   output logic        exe_vld,
   output logic [7:0]  exe_op,
   output logic [7:0]  exe_arg,
   input  logic        exe_done,
   input  logic        stat_req,
   input  logic [7:0]  stat_byte,
   output logic        stat_gnt,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, EXEC, ACK_REQ} cmd_state_t;
   typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

   cmd_state_t       cmd_state_reg, cmd_state_next;
   tx_state_t        tx_state_reg, tx_state_next;
   logic [TMR_W-1:0] timer_reg, timer_next;
   logic             nak_reg, nak_next;
   logic [7:0]       op_reg, op_next;
   logic [7:0]       arg_reg, arg_next;
   logic             clr_reg, clr_next;
   logic [7:0]       resp_reg, resp_next;
   logic             send_reg, send_next;
   logic             gnt_reg, gnt_next;
   logic             ack_req;
   logic             ack_gnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_state_reg <= IDLE;
         tx_state_reg  <= TX_IDLE;
         timer_reg     <= '0;
         nak_reg       <= 1'b0;
         op_reg        <= 8'h00;
         arg_reg       <= 8'h00;
         clr_reg       <= 1'b0;
         resp_reg      <= 8'h00;
         send_reg      <= 1'b0;
         gnt_reg       <= 1'b0;
      end else begin
         cmd_state_reg <= cmd_state_next;
         tx_state_reg  <= tx_state_next;
         timer_reg     <= timer_next;
         nak_reg       <= nak_next;
         op_reg        <= op_next;
         arg_reg       <= arg_next;
         clr_reg       <= clr_next;
         resp_reg      <= resp_next;
         send_reg      <= send_next;
         gnt_reg       <= gnt_next;
      end
   end

   // Command FSM; exe_done on the timeout cycle still yields an ACK.
   always_comb begin
      cmd_state_next = cmd_state_reg;
      timer_next     = '0;
      nak_next       = nak_reg;
      op_next        = op_reg;
      arg_next       = arg_reg;
      clr_next       = 1'b0;
      case (cmd_state_reg)
         IDLE: begin
            if (cmd_rdy) begin
               op_next        = cmd[15:8];
               arg_next       = cmd[7:0];
               clr_next       = 1'b1;
               cmd_state_next = EXEC;
            end
         end
         EXEC: begin
            timer_next = timer_reg + 1'b1;
            if (exe_done) begin
               nak_next       = 1'b0;
               cmd_state_next = ACK_REQ;
            end else if (timer_reg == TMR_LAST) begin
               nak_next       = 1'b1;
               cmd_state_next = ACK_REQ;
            end
         end
         ACK_REQ: begin
            timer_next = timer_reg;
            if (ack_gnt) begin
               cmd_state_next = IDLE;
            end
         end
         default: cmd_state_next = IDLE;
      endcase
   end

   assign ack_req = (cmd_state_reg == ACK_REQ);

   // Response arbiter: the ack path always beats a concurrent status request.
   always_comb begin
      tx_state_next = tx_state_reg;
      resp_next     = resp_reg;
      send_next     = 1'b0;
      gnt_next      = 1'b0;
      ack_gnt       = 1'b0;
      case (tx_state_reg)
         TX_IDLE: begin
            if (ack_req) begin
               ack_gnt       = 1'b1;
               resp_next     = nak_reg ? NAK_BYTE : ACK_BYTE;
               send_next     = 1'b1;
               tx_state_next = TX_BUSY;
            end else if (stat_req) begin
               resp_next     = stat_byte;
               send_next     = 1'b1;
               gnt_next      = 1'b1;
               tx_state_next = TX_BUSY;
            end
         end
         TX_BUSY: begin
            if (resp_sent) begin
               tx_state_next = TX_IDLE;
            end
         end
      endcase
   end

   assign clr_cmd_rdy = clr_reg;
   assign send_resp   = send_reg;
   assign resp        = resp_reg;
   assign stat_gnt    = gnt_reg;
   assign exe_vld     = (cmd_state_reg == EXEC);
   assign exe_op      = op_reg;
   assign exe_arg     = arg_reg;
   assign busy        = (cmd_state_reg != IDLE);

endmodule
